// File: rtl/io_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : io_deserializer
// Brief    : Serial-to-parallel input stage with word strobe and bitslip
//            alignment, fed from the input buffer pad bit.
// Revision : 1.0 - initial release
// ============================================================================
module io_deserializer #(
   parameter int WIDTH      = 4,
   parameter     DATA_ORDER = "MSB_FIRST"
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             D,
   input  logic             EN,
   input  logic             BITSLIP,
   output logic [WIDTH-1:0] Q,
   output logic             DATA_VALID,
   output logic             SLIP_BUSY
);

   localparam int CNT_W     = $clog2(WIDTH);
   localparam bit LSB_ORDER = (DATA_ORDER == "LSB_FIRST");

   if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
      $fatal(1, "io_deserializer: WIDTH must be in 3..10");
   end
   if (DATA_ORDER != "MSB_FIRST" && DATA_ORDER != "LSB_FIRST") begin : g_bad_order
      $fatal(1, "io_deserializer: DATA_ORDER must be MSB_FIRST or LSB_FIRST");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_SLIP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               dv_q, dv_d;
   logic               busy_q, busy_d;
   logic               bs_q;
   logic               bs_rise;
   logic [WIDTH-1:0]   sr_shift;

   if (LSB_ORDER) begin : g_lsb_first
      assign sr_shift = {D, sr_q[WIDTH-1:1]};
   end else begin : g_msb_first
      assign sr_shift = {sr_q[WIDTH-2:0], D};
   end

   assign bs_rise = BITSLIP & ~bs_q;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      dv_d    = 1'b0;
      busy_d  = 1'b0;
      if (!EN) begin
         // Disabling drops the partial word and any pending slip
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sr_d    = sr_shift;
               cnt_d   = CNT_W'(1);
               state_d = ST_RUN;
            end
            ST_RUN: begin
               sr_d = sr_shift;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  cnt_d = '0;
                  q_d   = sr_shift;
                  dv_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (bs_rise) begin
                  state_d = ST_SLIP;
                  busy_d  = 1'b1;
               end
            end
            ST_SLIP: begin
               // Extra uncounted shift pushes the word boundary one bit later
               sr_d    = sr_shift;
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         dv_q    <= 1'b0;
         busy_q  <= 1'b0;
         bs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         dv_q    <= dv_d;
         busy_q  <= busy_d;
         bs_q    <= BITSLIP;
      end
   end

   assign Q          = q_q;
   assign DATA_VALID = dv_q;
   assign SLIP_BUSY  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_io_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_deserializer
// Brief    : Bench for io_deserializer (WIDTH=4 MSB_FIRST and WIDTH=10
//            LSB_FIRST instances) against a sample-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_deserializer;

   logic       clk;
   logic       rst_n;
   logic       d;
   logic       en;
   logic       bs;
   logic [3:0] q4;
   logic       dv4, busy4;
   logic [9:0] q10;
   logic       dv10, busy10;

   int errors = 0;
   int checks = 0;
   int busy_cnt4 = 0;

   io_deserializer #(.WIDTH(4), .DATA_ORDER("MSB_FIRST")) u_dut4 (
      .CLK(clk), .RST(rst_n), .D(d), .EN(en), .BITSLIP(bs),
      .Q(q4), .DATA_VALID(dv4), .SLIP_BUSY(busy4)
   );

   io_deserializer #(.WIDTH(10), .DATA_ORDER("LSB_FIRST")) u_dut10 (
      .CLK(clk), .RST(rst_n), .D(d), .EN(en), .BITSLIP(bs),
      .Q(q10), .DATA_VALID(dv10), .SLIP_BUSY(busy10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: a word is the last w enabled samples; completion after w counted
   // samples since enable, a slip sample is taken but not counted.
   typedef struct {
      bit         active;
      bit         slipping;
      int         counted;
      bit         bs_prev;
      logic [9:0] hist;
      logic [9:0] q;
      bit         dv;
      bit         busy;
   } mstate_t;

   function automatic mstate_t model_reset();
      mstate_t s;
      s.active = 0; s.slipping = 0; s.counted = 0; s.bs_prev = 0;
      s.hist = '0; s.q = '0; s.dv = 0; s.busy = 0;
      return s;
   endfunction

   function automatic mstate_t model_step(mstate_t s, int w, bit lsb,
                                          bit ien, bit id, bit ibs);
      mstate_t n;
      bit      rise;
      n       = s;
      n.dv    = 0;
      n.busy  = 0;
      rise    = ibs && !s.bs_prev;
      n.bs_prev = ibs;
      if (!ien) begin
         n.active = 0; n.slipping = 0; n.counted = 0;
      end else begin
         n.hist = {s.hist[8:0], id};
         if (!s.active) begin
            n.active  = 1;
            n.counted = 1;
         end else if (s.slipping) begin
            n.slipping = 0;
         end else begin
            n.counted = s.counted + 1;
            if (n.counted == w) begin
               n.counted = 0;
               n.dv      = 1;
               n.q       = '0;
               for (int i = 0; i < w; i++)
                  n.q[i] = lsb ? n.hist[w-1-i] : n.hist[i];
            end
            if (rise) begin
               n.slipping = 1;
               n.busy     = 1;
            end
         end
      end
      return n;
   endfunction

   mstate_t m4, m10;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m4  = model_reset();
         m10 = model_reset();
      end else begin
         m4  = model_step(m4, 4, 1'b0, en, d, bs);
         m10 = model_step(m10, 10, 1'b1, en, d, bs);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("model_q4",     32'(q4),     32'(m4.q[3:0]));
         chk("model_dv4",    32'(dv4),    32'(m4.dv));
         chk("model_busy4",  32'(busy4),  32'(m4.busy));
         chk("model_q10",    32'(q10),    32'(m10.q));
         chk("model_dv10",   32'(dv10),   32'(m10.dv));
         chk("model_busy10", 32'(busy10), 32'(m10.busy));
         if (busy4) busy_cnt4++;
      end
   end

   // One sample per cycle; returns 1 time unit after the capturing edge
   task automatic cyc(input bit ien, input bit id, input bit ibs);
      @(negedge clk);
      en = ien; d = id; bs = ibs;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; en = 1'b0; bs = 1'b0; d = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [3:0] pat;
   int         ph;

   task automatic stream(input int n, input bit ibs);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, pat[3 - (ph % 4)], ibs);
         ph++;
      end
   endtask

   task automatic slip_and_check(input logic [3:0] exp, input string name);
      busy_cnt4 = 0;
      stream(1, 1'b1);
      stream(12, 1'b0);
      chk({name, "_busy_count"}, 32'(busy_cnt4), 32'd1);
      chk(name, 32'(q4), 32'(exp));
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; d = 1'b0; bs = 1'b0;
      m4 = model_reset(); m10 = model_reset();
      pat = 4'b1011; ph = 0;

      #2;
      chk("reset_q4",    32'(q4),    32'd0);
      chk("reset_dv4",   32'(dv4),   32'd0);
      chk("reset_busy4", 32'(busy4), 32'd0);
      chk("reset_q10",   32'(q10),   32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Word assembly 1,0,1,1,0,1,1,0
      cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 0);
      chk("asm_word0",    32'(q4),  32'h0000000b);
      chk("asm_word0_dv", 32'(dv4), 32'd1);
      cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 0, 0);
      chk("asm_word1",    32'(q4),  32'h00000006);
      chk("asm_word1_dv", 32'(dv4), 32'd1);

      // Single-pulse bitslips, four of them restore alignment
      do_reset(); ph = 0;
      stream(8, 1'b0);
      chk("slip_locked", 32'(q4), 32'hb);
      slip_and_check(4'b0111, "slip1");
      slip_and_check(4'b1110, "slip2");
      slip_and_check(4'b1101, "slip3");
      slip_and_check(4'b1011, "slip4");

      // Held BITSLIP is a single request
      do_reset(); ph = 0;
      stream(8, 1'b0);
      busy_cnt4 = 0;
      stream(10, 1'b1);
      stream(8, 1'b0);
      chk("held_busy_count", 32'(busy_cnt4), 32'd1);
      chk("held_word",       32'(q4),        32'h7);
      slip_and_check(4'b1110, "held_reraise");

      // Mid-word disable
      cyc(0, 0, 0);
      cyc(1, 1, 0); cyc(1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1'($urandom_range(0, 1)), 0);
         chk("gap_dv", 32'(dv4), 32'd0);
      end
      chk("gap_q_held", 32'(q4), 32'he);
      cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 0, 0);
      chk("regain_word", 32'(q4),  32'h2);
      chk("regain_dv",   32'(dv4), 32'd1);

      // Asynchronous reset between edges after two bits
      cyc(1, 1, 0); cyc(1, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_q4",  32'(q4),  32'd0);
      chk("async_rst_dv4", 32'(dv4), 32'd0);
      @(negedge clk);
      en = 1'b0;
      rst_n = 1'b1;
      cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
      chk("post_rst_word", 32'(q4),  32'hd);
      chk("post_rst_dv",   32'(dv4), 32'd1);

      // WIDTH=10 LSB_FIRST
      do_reset();
      for (int i = 0; i < 10; i++)
         cyc(1, (i == 0 || i == 9), 0);
      chk("w10_word", 32'(q10),  32'h201);
      chk("w10_dv",   32'(dv10), 32'd1);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0));
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
